// File: rtl/id_ex_ctrl_if.sv
// Bundle between the IF/ID side of the core and the ID/EX control stage.
// master drives the instruction, stall and flush; slave is the decode stage.
interface id_ex_ctrl_if #(
    parameter int RF_ADDR_W = 5
);
    logic                 id_valid;
    logic [31:0]          id_instr;
    logic                 stall;
    logic                 flush;
    logic                 id_hold;

    logic                 ex_valid;
    logic                 ex_jalr;
    logic                 ex_jal;
    logic                 ex_branch;
    logic                 ex_memread;
    logic                 ex_memtoreg;
    logic                 ex_memwrite;
    logic                 ex_alusrc;
    logic                 ex_regwrite;
    logic [1:0]           ex_aluop;
    logic                 ex_lui;
    logic                 ex_auipc;
    logic [RF_ADDR_W-1:0] ex_rd;
    logic [RF_ADDR_W-1:0] ex_rs1;
    logic [RF_ADDR_W-1:0] ex_rs2;
    logic [2:0]           ex_funct3;
    logic                 ex_funct7b5;
    logic                 ex_illegal;

    modport master (
        output id_valid, id_instr, stall, flush,
        input  id_hold, ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread,
               ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop,
               ex_lui, ex_auipc, ex_rd, ex_rs1, ex_rs2, ex_funct3,
               ex_funct7b5, ex_illegal
    );

    modport slave (
        input  id_valid, id_instr, stall, flush,
        output id_hold, ex_valid, ex_jalr, ex_jal, ex_branch, ex_memread,
               ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop,
               ex_lui, ex_auipc, ex_rd, ex_rs1, ex_rs2, ex_funct3,
               ex_funct7b5, ex_illegal
    );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// RV32I decode + ID/EX pipeline register with load-use hazard bubbling.
// Define ID_EX_UPPER_IMM_EN to decode LUI/AUIPC; otherwise they are illegal.
module id_ex_ctrl_stage #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int RF_ADDR_W        = 5
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_ctrl_if.slave  bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`ifdef ID_EX_UPPER_IMM_EN
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

    typedef struct packed {
        logic       jalr;
        logic       jal;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic       lui;
        logic       auipc;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic                 valid;
        ctrl_t                ctrl;
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic [2:0]           funct3;
        logic                 funct7b5;
    } bundle_t;

    typedef enum logic {IDLE, BUBBLE} state_t;

    state_t  state, state_n;
    logic [1:0] cnt, cnt_n;
    ctrl_t   dec;
    bundle_t nxt, ex;
    logic    rs1_used, rs2_used, known, hazard_now, id_hold;
    logic    unused_instr_bits;

    assign unused_instr_bits = ^{bus.id_instr[31], bus.id_instr[29:25]};

    // Opcode decode; controls are masked when the ID slot is empty
    always_comb begin
        dec      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        known    = 1'b1;
        case (bus.id_instr[6:0])
            OP_R:      begin dec.regwrite = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_I:      begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b01;
                             rs1_used = 1'b1; end
            OP_LOAD:   begin dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.alusrc = 1'b1;
                             dec.regwrite = 1'b1; dec.aluop = 2'b10; rs1_used = 1'b1; end
            OP_STORE:  begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b10;
                             rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_BRANCH: begin dec.branch = 1'b1; rs1_used = 1'b1; rs2_used = 1'b1; end
            OP_JAL:    begin dec.jal = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11; end
            OP_JALR:   begin dec.jalr = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1;
                             dec.aluop = 2'b11; rs1_used = 1'b1; end
`ifdef ID_EX_UPPER_IMM_EN
            OP_LUI:    begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b01;
                             dec.lui = 1'b1; end
            OP_AUIPC:  begin dec.regwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b01;
                             dec.auipc = 1'b1; end
`endif
            default:   known = 1'b0;
        endcase
        dec.illegal = bus.id_valid & ~known;

        nxt          = '0;
        nxt.valid    = bus.id_valid;
        nxt.ctrl     = bus.id_valid ? dec : '0;
        nxt.rd       = RF_ADDR_W'(bus.id_instr[11:7]);
        nxt.rs1      = RF_ADDR_W'(bus.id_instr[19:15]);
        nxt.rs2      = RF_ADDR_W'(bus.id_instr[24:20]);
        nxt.funct3   = bus.id_instr[14:12];
        nxt.funct7b5 = bus.id_instr[30];
    end

    // A load in EX whose destination feeds the ID instruction must be waited out
    assign hazard_now = bus.id_valid & ex.valid & ex.ctrl.memread & (ex.rd != '0) &
                        ((rs1_used & (ex.rd == nxt.rs1)) | (rs2_used & (ex.rd == nxt.rs2)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Bubble sequencer: the first bubble is taken from IDLE, the rest counted in BUBBLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (bus.flush) begin
            state_n = IDLE;
            cnt_n   = 2'd0;
        end else if (!bus.stall) begin
            case (state)
                IDLE: begin
                    if (hazard_now && LOAD_USE_BUBBLES > 1) begin
                        state_n = BUBBLE;
                        cnt_n   = 2'(LOAD_USE_BUBBLES - 1);
                    end
                end
                BUBBLE: begin
                    if (cnt == 2'd1) begin
                        state_n = IDLE;
                        cnt_n   = 2'd0;
                    end else begin
                        cnt_n = cnt - 2'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        id_hold = (state == BUBBLE) | ((state == IDLE) & hazard_now);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex <= '0;
        end else if (bus.flush) begin
            ex <= '0;
        end else if (!bus.stall) begin
            ex <= id_hold ? '0 : nxt;
        end
    end

    assign bus.id_hold     = id_hold;
    assign bus.ex_valid    = ex.valid;
    assign bus.ex_jalr     = ex.ctrl.jalr;
    assign bus.ex_jal      = ex.ctrl.jal;
    assign bus.ex_branch   = ex.ctrl.branch;
    assign bus.ex_memread  = ex.ctrl.memread;
    assign bus.ex_memtoreg = ex.ctrl.memtoreg;
    assign bus.ex_memwrite = ex.ctrl.memwrite;
    assign bus.ex_alusrc   = ex.ctrl.alusrc;
    assign bus.ex_regwrite = ex.ctrl.regwrite;
    assign bus.ex_aluop    = ex.ctrl.aluop;
    assign bus.ex_lui      = ex.ctrl.lui;
    assign bus.ex_auipc    = ex.ctrl.auipc;
    assign bus.ex_illegal  = ex.ctrl.illegal;
    assign bus.ex_rd       = ex.rd;
    assign bus.ex_rs1      = ex.rs1;
    assign bus.ex_rs2      = ex.rs2;
    assign bus.ex_funct3   = ex.funct3;
    assign bus.ex_funct7b5 = ex.funct7b5;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed + randomized bench for id_ex_ctrl_stage against an opcode-table reference model.
module tb_id_ex_ctrl_stage;

    localparam int BUBBLES = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state: what EX should hold and how many forced bubbles remain
    logic        expValid;
    logic [12:0] expCtrl;
    logic [18:0] expFields;
    int          holdLeft;
    logic        lastHold;
    int          holds;

    id_ex_ctrl_if #(.RF_ADDR_W(5)) bus ();

    id_ex_ctrl_stage #(.LOAD_USE_BUBBLES(BUBBLES), .RF_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {jalr,jal,branch,memread,memtoreg,memwrite,alusrc,regwrite,aluop,lui,auipc,unknown}
    function automatic logic [12:0] decodeRef(input logic [6:0] op);
        case (op)
            7'b0110011: return 13'b0000000100000;
            7'b0010011: return 13'b0000001101000;
            7'b0000011: return 13'b0001101110000;
            7'b0100011: return 13'b0000011010000;
            7'b1100011: return 13'b0010000000000;
            7'b1101111: return 13'b0100000111000;
            7'b1100111: return 13'b1000001111000;
`ifdef ID_EX_UPPER_IMM_EN
            7'b0110111: return 13'b0000001101100;
            7'b0010111: return 13'b0000001101010;
`endif
            default:    return 13'b0000000000001;
        endcase
    endfunction

    function automatic logic readsRs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                          7'b1100011, 7'b1100111};
    endfunction

    function automatic logic readsRs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic modelHazard(input logic v, input logic [31:0] ins);
        logic [4:0] rdEx;
        rdEx = expFields[18:14];
        return v && expValid && expCtrl[9] && (rdEx != 5'd0) &&
               ((readsRs1(ins[6:0]) && rdEx == ins[19:15]) ||
                (readsRs2(ins[6:0]) && rdEx == ins[24:20]));
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check("ex_valid", 32'(bus.ex_valid), 32'(expValid));
        check("ex_ctrl", 32'({bus.ex_jalr, bus.ex_jal, bus.ex_branch, bus.ex_memread,
                              bus.ex_memtoreg, bus.ex_memwrite, bus.ex_alusrc,
                              bus.ex_regwrite, bus.ex_aluop, bus.ex_lui, bus.ex_auipc,
                              bus.ex_illegal}), 32'(expCtrl));
        check("ex_fields", 32'({bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_funct3,
                                bus.ex_funct7b5}), 32'(expFields));
    endtask

    task automatic modelReset();
        expValid  = 1'b0;
        expCtrl   = '0;
        expFields = '0;
        holdLeft  = 0;
    endtask

    // One clock: drive at negedge, check id_hold, then check EX just after posedge
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic st, input logic fl);
        logic hold;
        @(negedge clk);
        bus.id_valid = v;
        bus.id_instr = ins;
        bus.stall    = st;
        bus.flush    = fl;
        #1;
        hold = (holdLeft > 0) || modelHazard(v, ins);
        check("id_hold", 32'(bus.id_hold), 32'(hold));
        lastHold = bus.id_hold;
        @(posedge clk);
        if (fl) begin
            modelReset();
        end else if (!st) begin
            if (hold) begin
                holdLeft  = (holdLeft > 0) ? holdLeft - 1 : BUBBLES - 1;
                expValid  = 1'b0;
                expCtrl   = '0;
                expFields = '0;
            end else begin
                expValid  = v;
                expCtrl   = v ? decodeRef(ins[6:0]) : 13'd0;
                expFields = {ins[11:7], ins[19:15], ins[24:20], ins[14:12], ins[30]};
            end
        end
        #1;
        checkOutput();
    endtask

    localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
    localparam logic [31:0] LW_5_1    = 32'h0000A283;
    localparam logic [31:0] ADD_6_5_7 = 32'h00728333;
    localparam logic [31:0] ADD_6_8_7 = 32'h00740333;
    localparam logic [31:0] LW_8_1    = 32'h0000A403;
    localparam logic [31:0] LUI_4     = 32'h12345237;
    localparam logic [31:0] BAD_OP    = 32'h0000007F;

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] ins;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        bus.id_valid = 1'b0;
        bus.id_instr = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        modelReset();
        #12;
        checkOutput();
        check("reset_id_hold", 32'(bus.id_hold), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ADD decodes to an R-type bundle one cycle later
        applyStimulus(1'b1, ADD_3_1_2, 1'b0, 1'b0);
        check("add_rd", 32'(bus.ex_rd), 32'd3);
        check("add_aluop", 32'(bus.ex_aluop), 32'd0);

        // Asynchronous reset mid-run clears EX without a clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        check("rst_id_hold", 32'(bus.id_hold), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load-use: hold for exactly BUBBLES cycles, then the ADD is accepted
        applyStimulus(1'b1, LW_5_1, 1'b0, 1'b0);
        holds = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b0);
            if (lastHold) holds++;
            else break;
        end
        check("loaduse_holds", 32'(holds), 32'(BUBBLES));
        check("loaduse_add_valid", 32'(bus.ex_valid), 32'd1);

        // Independent register: no hold
        applyStimulus(1'b1, LW_5_1, 1'b0, 1'b0);
        applyStimulus(1'b1, ADD_6_8_7, 1'b0, 1'b0);
        check("nohaz_hold", 32'(lastHold), 32'd0);

        // Flush in the second bubble cycle returns to IDLE
        applyStimulus(1'b1, LW_5_1, 1'b0, 1'b0);
        applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b0);
        applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b1);
        applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b0);
        check("flush_release", 32'(lastHold), 32'd0);

        // Stall during BUBBLE freezes the count
        applyStimulus(1'b1, LW_5_1, 1'b0, 1'b0);
        applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b0);
        applyStimulus(1'b1, ADD_6_5_7, 1'b1, 1'b0);
        applyStimulus(1'b1, ADD_6_5_7, 1'b1, 1'b0);
        applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b0);
        check("stall_last_bubble", 32'(lastHold), 32'd1);
        applyStimulus(1'b1, ADD_6_5_7, 1'b0, 1'b0);
        check("stall_release", 32'(bus.ex_valid), 32'd1);

        // Illegal opcode only flagged for a valid instruction
        applyStimulus(1'b1, BAD_OP, 1'b0, 1'b0);
        check("illegal_valid", 32'(bus.ex_illegal), 32'd1);
        applyStimulus(1'b0, BAD_OP, 1'b0, 1'b0);
        check("illegal_invalid", 32'(bus.ex_illegal), 32'd0);

        // LUI after a load to x8 (LUI's rs1 field) never holds
        applyStimulus(1'b1, LW_8_1, 1'b0, 1'b0);
        applyStimulus(1'b1, LUI_4, 1'b0, 1'b0);
        check("lui_hold", 32'(lastHold), 32'd0);
`ifdef ID_EX_UPPER_IMM_EN
        check("lui_flag", 32'(bus.ex_lui), 32'd1);
`else
        check("lui_illegal", 32'(bus.ex_illegal), 32'd1);
`endif

        // Randomized traffic with small register indices to provoke hazards
        for (int n = 0; n < 400; n++) begin
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 7) != 0, ins,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
Registered RV32I decode stage. It takes the fetched instruction, produces the full control bundle (jalr/jal/branch/mem/alusrc/regwrite/aluop plus register fields), and latches it into the ID/EX pipeline register. It adds a load-use hazard unit with a programmable bubble count, external stall/flush, and illegal-opcode flagging. It sits between IF/ID and the EX stage of the pipelined core.

Parameters:
LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..3.
RF_ADDR_W, 5, register-index width.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  id_instr holds a real instruction
id_instr  in  32  instruction in ID
stall  in  1  memory stall; freeze ID/EX register and hazard FSM
flush  in  1  branch/jump redirect; kill the ID instruction
id_hold  out  1  combinational; upstream must hold PC and IF/ID this cycle
ex_valid  out  1  EX slot holds a real instruction
ex_jalr, ex_jal, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  control bits
ex_aluop  out  2  00 R/B, 01 I, 10 load/store, 11 jal/jalr
ex_lui, ex_auipc  out  1 each  upper-immediate ops (see Optional Feature)
ex_rd, ex_rs1, ex_rs2  out  RF_ADDR_W each  instr[11:7], [19:15], [24:20]
ex_funct3  out  3  instr[14:12]
ex_funct7b5  out  1  instr[30]
ex_illegal  out  1  valid instruction with unrecognised opcode

Behaviour:
- Decode is combinational on id_instr[6:0]:
  - R 0110011: regwrite, aluop 00.
  - I 0010011: alusrc, regwrite, aluop 01.
  - LOAD 0000011: memread, memtoreg, alusrc, regwrite, aluop 10.
  - STORE 0100011: memwrite, alusrc, aluop 10.
  - B 1100011: branch, aluop 00.
  - JAL 1101111: jal, regwrite, aluop 11.
  - JALR 1100111: jalr, alusrc, regwrite, aluop 11.
  - Any other opcode: all controls 0; illegal = id_valid.
- rs1 is used by R, I, LOAD, STORE, B and JALR. rs2 is used by R, STORE and B.
- hazard_now = id_valid & ex_valid & ex_memread & (ex_rd != 0) & ((rs1 used & ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
- FSM states are IDLE and BUBBLE, with a 2-bit counter cnt.
  - id_hold = state==BUBBLE | (state==IDLE & hazard_now).
- ID/EX update on each rising clk edge, priority order:
  1. rst: every ex_* output is 0, state IDLE, cnt 0. This applies asynchronously at any time, including mid-bubble.
  2. flush: insert a bubble (ex_valid and all controls 0; register fields don't-care, driven 0), state IDLE, cnt 0. Flush overrides stall.
  3. stall: all ex_* outputs, state and cnt hold.
  4. id_hold: insert a bubble.
     - IDLE with hazard_now and LOAD_USE_BUBBLES>1: go to BUBBLE, cnt = LOAD_USE_BUBBLES-1.
     - BUBBLE with cnt==1: go to IDLE, cnt 0. Otherwise cnt decrements.
  5. else: latch the decoded bundle; ex_valid = id_valid. If id_valid=0, all controls are 0.
- hazard_now is not re-evaluated while in BUBBLE; the bubble count is fixed at LOAD_USE_BUBBLES.
- A load into x0 never causes a hazard.
- Latency: 1 cycle from ID to the ex_* outputs. id_hold is same-cycle.

Optional Feature:
Macro: ID_EX_UPPER_IMM_EN.
- Defined:
  - LUI 0110111 decodes as regwrite, alusrc, aluop 01, ex_lui=1; rs1 and rs2 not used.
  - AUIPC 0010111 decodes the same way but sets ex_auipc=1 instead of ex_lui.
- Not defined: ex_lui and ex_auipc are tied 0, and both opcodes are illegal.

Test Plan:
- Reset: assert rst mid-run, with ex_valid=1 and ex_regwrite=1 -> all ex_* outputs 0 immediately; id_hold=0.
- ADD x3,x1,x2 (0x002081B3), id_valid=1 -> next cycle: ex_valid=1, ex_regwrite=1, ex_aluop=00, ex_rd=3, ex_rs1=1, ex_rs2=2; id_hold stays 0.
- LW x5,0(x1) then ADD x6,x5,x7 with LOAD_USE_BUBBLES=2 -> id_hold high for exactly 2 cycles; 2 bubbles (ex_valid=0); the ADD reaches EX on the 3rd cycle. The same sequence with the ADD reading x8 -> no hold.
- Same load-use sequence with flush asserted in the 2nd bubble cycle -> state IDLE, id_hold drops next cycle. With stall asserted during BUBBLE instead -> cnt and state freeze; the bubble total is still 2.
- Opcode 0x7F, id_valid=1 -> ex_illegal=1, all controls 0. Same opcode with id_valid=0 -> ex_illegal=0.
- LUI x4,0x12345 (0x12345237) -> with the macro: ex_lui=1, ex_regwrite=1, ex_aluop=01, no hazard even if ex_rd==instr[19:15]. Without the macro: ex_illegal=1.
